// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command scheduler: key/value layout and FSM states.
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;
endpackage

// File: rtl/pq_sync_fifo.sv
// Small synchronous FIFO; head is the oldest entry and is valid whenever !empty.
module pq_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pq_cmd_sched.sv
// Issues at most one enq/deq/replace per cycle to the downstream priority queue,
// buffering inserts in a small FIFO and returning dequeued entries on a registered port.
module pq_cmd_sched
    import pq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [KV_WIDTH-1:0]  in_kv,
    output logic                 in_ready,
    input  logic                 deq_req,
    output logic                 deq_ack,
    input  logic                 drain,
    output logic                 drain_busy,
    output logic                 out_valid,
    output logic [KV_WIDTH-1:0]  out_kv,
    input  logic                 out_ready,
    output logic                 pq_enq,
    output logic                 pq_deq,
    output logic                 pq_replace,
    output logic [KV_WIDTH-1:0]  pq_kvi,
    input  logic [KV_WIDTH-1:0]  pq_kvo,
    input  logic                 pq_empty,
    input  logic                 pq_full,
    output logic [CNT_WIDTH-1:0] n_enq,
    output logic [CNT_WIDTH-1:0] n_deq
);
    sched_state_t        state, state_next;
    logic                fifo_full, fifo_empty;
    logic [KV_WIDTH-1:0] fifo_head;
    logic                fifo_pop;
    logic                slot_free;
    logic                capture;

    // in_ready looks only at registered occupancy, so a full FIFO never accepts.
    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid || out_ready;
    assign pq_kvi    = fifo_head;
    assign drain_busy = (state == DRAIN);
    assign fifo_pop  = pq_enq || pq_replace;
    assign capture   = pq_deq || pq_replace;

    pq_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KV_WIDTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (in_kv),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pq_enq     = 1'b0;
        pq_deq     = 1'b0;
        pq_replace = 1'b0;
        deq_ack    = 1'b0;
        unique case (state)
            RUN: begin
                if (drain) state_next = DRAIN;
                if (!fifo_empty && deq_req && !pq_empty && slot_free) begin
                    pq_replace = 1'b1;
                    deq_ack    = 1'b1;
                end else if (deq_req && !pq_empty && slot_free) begin
                    pq_deq  = 1'b1;
                    deq_ack = 1'b1;
                end else if (!fifo_empty && !pq_full) begin
                    pq_enq = 1'b1;
                end
            end
            DRAIN: begin
                // Consumer requests and FIFO-to-PQ inserts pause until the PQ is empty.
                if (!pq_empty && slot_free) pq_deq = 1'b1;
                if (pq_empty && !out_valid) state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_kv    <= '0;
            n_enq     <= '0;
            n_deq     <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                out_valid <= 1'b1;
                out_kv    <= pq_kvo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            n_enq <= n_enq + CNT_WIDTH'(pq_enq || pq_replace);
            n_deq <= n_deq + CNT_WIDTH'(pq_deq || pq_replace);
        end
    end

    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst)
        (pq_deq || pq_replace) |-> !pq_empty);
    a_no_enq_full: assert property (@(posedge clk) disable iff (rst)
        pq_enq |-> !pq_full);
    a_onehot_cmd: assert property (@(posedge clk) disable iff (rst)
        $onehot0({pq_enq, pq_deq, pq_replace}));
endmodule

// File: tb/tb_pq_cmd_sched.sv
// Directed bench: a min-key PQ plant, a queue-based scheduler model compared every cycle,
// and literal checks along the test-plan scenarios.
module tb_pq_cmd_sched;
    import pq_pkg::*;

    localparam int FD     = 4;
    localparam int CW     = 16;
    localparam int PQ_CAP = 8;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, deq_req, deq_ack, drain, drain_busy;
    logic out_valid, out_ready, pq_enq, pq_deq, pq_replace, pq_empty, pq_full;
    logic [KV_WIDTH-1:0] in_kv, out_kv, pq_kvi, pq_kvo;
    logic [CW-1:0] n_enq, n_deq;

    always #5 clk = ~clk;

    pq_cmd_sched #(.FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_kv(in_kv), .in_ready(in_ready),
        .deq_req(deq_req), .deq_ack(deq_ack), .drain(drain), .drain_busy(drain_busy),
        .out_valid(out_valid), .out_kv(out_kv), .out_ready(out_ready),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_replace(pq_replace), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_empty(pq_empty), .pq_full(pq_full),
        .n_enq(n_enq), .n_deq(n_deq)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- PQ plant (min key first, FIFO among equal keys)
    kv_t  pq_q[$];
    logic cap_full;
    logic force_full = 1'b0;
    assign pq_full = cap_full || force_full;

    task automatic pq_insert(kv_t kv);
        int i = 0;
        while (i < pq_q.size() && pq_q[i].key <= kv.key) i++;
        pq_q.insert(i, kv);
    endtask

    task automatic pq_drive();
        pq_empty = (pq_q.size() == 0);
        cap_full = (pq_q.size() >= PQ_CAP);
        pq_kvo   = (pq_q.size() > 0) ? pq_q[0] : '0;
    endtask

    initial pq_drive();

    always @(posedge clk) begin
        logic e, d, r;
        kv_t  k;
        e = pq_enq; d = pq_deq; r = pq_replace; k = pq_kvi;
        #1;
        if ((d === 1'b1 || r === 1'b1) && pq_q.size() > 0) void'(pq_q.pop_front());
        if (e === 1'b1 || r === 1'b1) pq_insert(k);
        pq_drive();
    end

    // ---------------- scheduler model
    kv_t         m_fifo[$];
    logic        m_outv;
    kv_t         m_outkv;
    logic        m_drain;
    logic [CW-1:0] m_nenq, m_ndeq;
    bit          m_init = 0;
    int          enq_seen = 0;

    always @(negedge clk) begin
        logic ee, ed, er, can_deq, has;
        int   sz;
        sz = m_fifo.size();
        has = (sz > 0);
        can_deq = !pq_empty && (!m_outv || out_ready);
        ee = 0; ed = 0; er = 0;
        if (!m_drain) begin
            if (has && deq_req && can_deq)       er = 1;
            else if (deq_req && can_deq)         ed = 1;
            else if (has && !pq_full)            ee = 1;
        end else if (can_deq) begin
            ed = 1;
        end
        if (m_init) begin
            check("pq_enq", pq_enq, ee);
            check("pq_deq", pq_deq, ed);
            check("pq_replace", pq_replace, er);
            check("deq_ack", deq_ack, !m_drain && (ed || er));
            check("in_ready", in_ready, sz < FD);
            check("out_valid", out_valid, m_outv);
            check("out_kv", out_kv, m_outkv);
            check("drain_busy", drain_busy, m_drain);
            check("n_enq", n_enq, m_nenq);
            check("n_deq", n_deq, m_ndeq);
            if (ee || er) check("pq_kvi", pq_kvi, m_fifo[0]);
            if (pq_enq === 1'b1) enq_seen++;
        end
        if (rst) begin
            m_fifo.delete();
            m_outv = 0; m_outkv = '0; m_drain = 0; m_nenq = '0; m_ndeq = '0;
            m_init = 1;
        end else if (m_init) begin
            if (ee || er) void'(m_fifo.pop_front());
            if (in_valid && sz < FD) m_fifo.push_back(kv_t'(in_kv));
            if (ed || er) begin
                m_outv = 1; m_outkv = kv_t'(pq_kvo);
            end else if (out_ready) begin
                m_outv = 0;
            end
            if (!m_drain && drain) m_drain = 1;
            else if (m_drain && pq_empty && !m_outv_prev_ok(m_outv, ed || er)) m_drain = 0;
            m_nenq = m_nenq + CW'(ee || er);
            m_ndeq = m_ndeq + CW'(ed || er);
        end
    end

    // Drain exit looks at out_valid as it stood this cycle, i.e. before the update above.
    logic m_outv_q;
    always @(negedge clk) m_outv_q <= m_outv;
    function automatic logic m_outv_prev_ok(logic now_v, logic captured);
        return m_outv_q;
    endfunction

    // ---------------- stimulus
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_kv = '0; deq_req = 0; drain = 0; out_ready = 0;
        step(); step();
        rst = 0;
        at_neg();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_kv", out_kv, 0);
        check("rst_n_enq", n_enq, 0);
        check("rst_drain_busy", drain_busy, 0);
        check("rst_in_ready", in_ready, 1);

        // three inserts into an empty PQ
        step(); in_valid = 1; in_kv = 16'h080e;
        step(); in_kv = 16'h0b0b;
        step(); in_kv = 16'h0909;
        step(); in_valid = 0;
        step();
        at_neg();
        check("t1_n_enq", n_enq, 3);
        check("t1_enq_pulses", enq_seen, 3);
        check("t1_out_valid", out_valid, 0);

        // plain dequeue of top (8,14)
        step(); deq_req = 1; out_ready = 1;
        at_neg();
        check("t2_pq_deq", pq_deq, 1);
        check("t2_deq_ack", deq_ack, 1);
        step(); deq_req = 0;
        at_neg();
        check("t2_out_valid", out_valid, 1);
        check("t2_out_kv", out_kv, 16'h080e);
        check("t2_n_deq", n_deq, 1);

        // replace: head (1,1) in, top (9,9) out
        step(); in_valid = 1; in_kv = 16'h0101;
        step(); in_valid = 0; deq_req = 1;
        at_neg();
        check("t3_replace", pq_replace, 1);
        check("t3_kvi", pq_kvi, 16'h0101);
        step(); deq_req = 0; out_ready = 0;
        at_neg();
        check("t3_out_kv", out_kv, 16'h0909);
        check("t3_n_enq", n_enq, 4);
        check("t3_n_deq", n_deq, 2);

        // output stalled: no removal, data held
        step(); deq_req = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t4_no_deq", pq_deq | pq_replace, 0);
            check("t4_hold_kv", out_kv, 16'h0909);
            step();
        end
        out_ready = 1;
        at_neg();
        check("t4_deq_resume", pq_deq, 1);
        step(); deq_req = 0;
        at_neg();
        check("t4_out_kv", out_kv, 16'h0101);
        check("t4_n_deq", n_deq, 3);

        // PQ full: FIFO fills, then drains one per cycle
        step(); force_full = 1; in_valid = 1; in_kv = 16'h0505;
        step(); in_kv = 16'h0606;
        step(); in_kv = 16'h0707;
        step(); in_kv = 16'h0404;
        step(); in_kv = 16'h0303;
        at_neg();
        check("t5_in_ready", in_ready, 0);
        check("t5_no_enq", pq_enq, 0);
        step(); in_valid = 0; force_full = 0;
        at_neg();
        check("t5_enq_resume", pq_enq, 1);
        for (int i = 0; i < 4; i++) step();
        at_neg();
        check("t5_n_enq", n_enq, 8);
        check("t5_in_ready_back", in_ready, 1);

        // remove two so the PQ holds three, then drain
        step(); deq_req = 1;
        step();
        step(); deq_req = 0;
        at_neg();
        check("t6_n_deq", n_deq, 5);
        step(); drain = 1;
        at_neg();
        check("t6_busy_pre", drain_busy, 0);
        step(); drain = 0; deq_req = 1;
        at_neg();
        check("t6_busy", drain_busy, 1);
        check("t6_ack_ignored", deq_ack, 0);
        check("t6_drain_deq", pq_deq, 1);
        begin
            int n = 0;
            while (drain_busy === 1'b1 && n < 20) begin
                step(); at_neg(); n++;
            end
            check("t6_drain_done", (n < 20), 1);
        end
        check("t6_n_deq_final", n_deq, 8);
        check("t6_empty_out", out_valid, 0);
        step(); deq_req = 0;

        // reset in the middle of a drain
        step(); in_valid = 1; in_kv = 16'h0202;
        step(); in_kv = 16'h0303;
        step(); in_valid = 0;
        step(); step(); out_ready = 0; drain = 1;
        step(); drain = 0;
        step(); step();
        at_neg();
        check("t7_busy", drain_busy, 1);
        check("t7_out_valid", out_valid, 1);
        step(); rst = 1;
        step(); rst = 0;
        at_neg();
        check("t7_rst_busy", drain_busy, 0);
        check("t7_rst_out_valid", out_valid, 0);
        check("t7_rst_out_kv", out_kv, 0);
        check("t7_rst_n_enq", n_enq, 0);
        check("t7_rst_n_deq", n_deq, 0);
        check("t7_rst_strobes", {pq_enq, pq_deq, pq_replace}, 0);
        step(); step();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
